// File: rtl/shim_trigger_pkg.sv
// -----------------------------------------------------------------------------
// shim_trigger_pkg
// Shared definitions for the trigger command sequencer:
//   - 3-bit trigger command opcodes
//   - command word field positions (type [31:29], log [28], value [27:0])
//   - fixed command words issued by the sequencer itself
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package shim_trigger_pkg;

    // Trigger core command opcodes
    localparam logic [2:0] OP_SYNC_CH         = 3'd1;
    localparam logic [2:0] OP_SET_LOCKOUT     = 3'd2;
    localparam logic [2:0] OP_EXPECT_EXT_TRIG = 3'd3;
    localparam logic [2:0] OP_DELAY           = 3'd4;
    localparam logic [2:0] OP_FORCE_TRIG      = 3'd5;
    localparam logic [2:0] OP_RESET_COUNT     = 3'd6;
    localparam logic [2:0] OP_CANCEL          = 3'd7;

    // Command word field positions
    localparam int CMD_TYPE_MSB  = 31;
    localparam int CMD_TYPE_LSB  = 29;
    localparam int CMD_LOG_BIT   = 28;
    localparam int CMD_VALUE_MSB = 27;
    localparam int CMD_VALUE_LSB = 0;

    // Words the sequencer generates on its own
    localparam logic [31:0] CANCEL_WORD   = {OP_CANCEL,  1'b0, 28'd0};  // 32'hE000_0000
    localparam logic [31:0] SYNC_LOG_WORD = {OP_SYNC_CH, 1'b1, 28'd0};  // 32'h3000_0000

    // Assemble a command word from its fields
    function automatic logic [31:0] make_cmd(input logic [2:0]  op,
                                             input logic        log_en,
                                             input logic [27:0] value);
        return {op, log_en, value};
    endfunction

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_PUSH     = 3'd2,
        ST_LOOP_END = 3'd3,
        ST_CANCEL   = 3'd4,
        ST_FINISH   = 3'd5
    } seq_state_e;

endpackage

// File: rtl/shim_trigger_seq_ram.sv
// -----------------------------------------------------------------------------
// shim_trigger_seq_ram
// Simple dual-port program memory: synchronous write, synchronous read with
// one cycle of latency. The read register only updates when rd_en_i is high,
// so it doubles as the holding register for the word being pushed.
// Contents are not reset.
//
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address (AW bits)
//   wr_data_i  : write data (DW bits)
//   rd_en_i    : read enable; rd_data_o loads mem[rd_addr_i] on the next edge
//   rd_addr_i  : read address (AW bits)
//   rd_data_o  : registered read data
// -----------------------------------------------------------------------------
module shim_trigger_seq_ram #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/shim_trigger_seq.sv
// -----------------------------------------------------------------------------
// shim_trigger_seq
// Command sequencer that replays a stored program of trigger command words
// into the trigger core command FIFO, honouring FIFO backpressure, and repeats
// the program loop_count times (0 = until abort). One word every two cycles.
//
// Build option:
//   SHIM_TRIGGER_SEQ_LOOP_SYNC_EN - when defined, every loop end pushes the
//   sync word 32'h3000_0000 before the next loop (or before finishing).
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   prog_wr_en/addr/data : program RAM write port (accepted only when idle)
//   prog_len          : words in program, 1..PROG_DEPTH valid
//   loop_count        : repetitions, 0 = forever
//   start, abort      : single-cycle control pulses
//   cmd_fifo_wr_en/wr_data/full : command FIFO write side
//   busy              : sequence active
//   done              : one-cycle pulse on completion (normal or cancelled)
//   loops_done        : completed loops, saturating
//   prog_ptr          : address of next word to fetch
//   bad_start         : sticky, start with illegal prog_len
//   prog_wr_err       : sticky, program write attempted while busy (dropped)
// -----------------------------------------------------------------------------
module shim_trigger_seq
    import shim_trigger_pkg::*;
#(
    parameter int PROG_AW    = 6,
    parameter int PROG_DEPTH = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_wr_en,
    input  logic [PROG_AW-1:0] prog_addr,
    input  logic [31:0]        prog_data,
    input  logic [PROG_AW:0]   prog_len,
    input  logic [15:0]        loop_count,
    input  logic               start,
    input  logic               abort,
    output logic               cmd_fifo_wr_en,
    output logic [31:0]        cmd_fifo_wr_data,
    input  logic               cmd_fifo_full,
    output logic               busy,
    output logic               done,
    output logic [15:0]        loops_done,
    output logic [PROG_AW-1:0] prog_ptr,
    output logic               bad_start,
    output logic               prog_wr_err
);

    localparam logic [PROG_AW:0] DEPTH_W = (PROG_AW+1)'(PROG_DEPTH);

    seq_state_e         state_q, state_d;
    logic [PROG_AW:0]   len_q, len_d;
    logic [15:0]        loop_cnt_q, loop_cnt_d;
    logic [15:0]        loops_q, loops_d;
    logic [PROG_AW-1:0] ptr_q, ptr_d;
    logic               bad_q, bad_d;
    logic               wr_err_q, wr_err_d;

    logic               ram_wr_en;
    logic               ram_rd_en;
    logic [31:0]        ram_rd_data;
    logic               last_word;
    logic               last_loop;
    logic               loop_ok;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Program writes are only safe while nothing is being replayed.
    assign ram_wr_en = prog_wr_en && (state_q == ST_IDLE);

    shim_trigger_seq_ram #(
        .AW (PROG_AW),
        .DW (32)
    ) u_ram (
        .clk_i     (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (prog_addr),
        .wr_data_i (prog_data),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (ptr_q),
        .rd_data_o (ram_rd_data)
    );

    assign last_word = ({1'b0, ptr_q} == (len_q - 1'b1));
    // Widen by one bit so loops_q+1 cannot wrap before comparing.
    assign last_loop = (loop_cnt_q != 16'd0) &&
                       (({1'b0, loops_q} + 17'd1) == {1'b0, loop_cnt_q});

    always_comb begin
        state_d          = state_q;
        len_d            = len_q;
        loop_cnt_d       = loop_cnt_q;
        loops_d          = loops_q;
        ptr_d            = ptr_q;
        bad_d            = bad_q;
        wr_err_d         = wr_err_q | (prog_wr_en && (state_q != ST_IDLE));
        ram_rd_en        = 1'b0;
        cmd_fifo_wr_en   = 1'b0;
        cmd_fifo_wr_data = 32'd0;
        done             = 1'b0;
        loop_ok          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((prog_len == '0) || (prog_len > DEPTH_W)) begin
                        bad_d = 1'b1;
                    end else begin
                        len_d      = prog_len;
                        loop_cnt_d = loop_count;
                        loops_d    = 16'd0;
                        ptr_d      = '0;
                        state_d    = ST_FETCH;
                    end
                end
            end

            ST_FETCH: begin
                ram_rd_en = 1'b1;
                state_d   = ST_PUSH;
            end

            // RAM read register holds the word until it is accepted.
            ST_PUSH: begin
                if (!cmd_fifo_full) begin
                    cmd_fifo_wr_en   = 1'b1;
                    cmd_fifo_wr_data = ram_rd_data;
                    if (last_word) begin
                        state_d = ST_LOOP_END;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_LOOP_END: begin
`ifdef SHIM_TRIGGER_SEQ_LOOP_SYNC_EN
                if (!cmd_fifo_full) begin
                    cmd_fifo_wr_en   = 1'b1;
                    cmd_fifo_wr_data = SYNC_LOG_WORD;
                    loop_ok          = 1'b1;
                end
`else
                loop_ok = 1'b1;
`endif
                // The loop is counted even if an abort arrives this cycle:
                // all of its words (and sync word, if any) have gone out.
                if (loop_ok) begin
                    loops_d = sat_inc16(loops_q);
                    if (last_loop) begin
                        state_d = ST_FINISH;
                    end else begin
                        ptr_d   = '0;
                        state_d = ST_FETCH;
                    end
                end
            end

            ST_CANCEL: begin
                if (!cmd_fifo_full) begin
                    cmd_fifo_wr_en   = 1'b1;
                    cmd_fifo_wr_data = CANCEL_WORD;
                    state_d          = ST_FINISH;
                end
            end

            ST_FINISH: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides the transition but not a write already presented
        // this cycle. Once cancelling or finishing there is nothing to abort.
        if (abort && (state_q == ST_FETCH || state_q == ST_PUSH ||
                      state_q == ST_LOOP_END)) begin
            state_d = ST_CANCEL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            loop_cnt_q <= 16'd0;
            loops_q    <= 16'd0;
            ptr_q      <= '0;
            bad_q      <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            loop_cnt_q <= loop_cnt_d;
            loops_q    <= loops_d;
            ptr_q      <= ptr_d;
            bad_q      <= bad_d;
            wr_err_q   <= wr_err_d;
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign loops_done  = loops_q;
    assign prog_ptr    = ptr_q;
    assign bad_start   = bad_q;
    assign prog_wr_err = wr_err_q;

endmodule

// File: tb/tb_shim_trigger_seq.sv
// -----------------------------------------------------------------------------
// tb_shim_trigger_seq
// Self-checking bench for shim_trigger_seq: a table of program runs
// {prog_len, loop_count, FIFO-full window -> loops_done} checked against a
// word-order model, plus hand sequences for illegal start, abort/cancel,
// dropped program writes and reset mid-sequence. Honours
// SHIM_TRIGGER_SEQ_LOOP_SYNC_EN for the expected sync words.
// -----------------------------------------------------------------------------
module tb_shim_trigger_seq;

    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk;
    logic          rst;
    logic          prog_wr_en;
    logic [AW-1:0] prog_addr;
    logic [31:0]   prog_data;
    logic [AW:0]   prog_len;
    logic [15:0]   loop_count;
    logic          start;
    logic          abort;
    logic          cmd_fifo_wr_en;
    logic [31:0]   cmd_fifo_wr_data;
    logic          cmd_fifo_full;
    logic          busy;
    logic          done;
    logic [15:0]   loops_done;
    logic [AW-1:0] prog_ptr;
    logic          bad_start;
    logic          prog_wr_err;

    shim_trigger_seq #(
        .PROG_AW    (AW),
        .PROG_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .prog_wr_en       (prog_wr_en),
        .prog_addr        (prog_addr),
        .prog_data        (prog_data),
        .prog_len         (prog_len),
        .loop_count       (loop_count),
        .start            (start),
        .abort            (abort),
        .cmd_fifo_wr_en   (cmd_fifo_wr_en),
        .cmd_fifo_wr_data (cmd_fifo_wr_data),
        .cmd_fifo_full    (cmd_fifo_full),
        .busy             (busy),
        .done             (done),
        .loops_done       (loops_done),
        .prog_ptr         (prog_ptr),
        .bad_start        (bad_start),
        .prog_wr_err      (prog_wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] W_CANCEL = 32'hE000_0000;
    localparam logic [31:0] W_SYNC   = 32'h3000_0000;

    typedef struct {
        logic [6:0]  len;
        logic [15:0] lc;
        int          full_start;
        int          full_len;
        logic [15:0] exp_loops;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] prog_mem [DEPTH];
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    int          done_cnt;
    int          full_viol;
    int          busy_after_done;
    int          busy_seen;
    int          timed_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        prog_wr_en    = 1'b0;
        cmd_fifo_full = 1'b0;
        @(negedge clk);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_loops", {16'd0, loops_done}, 32'd0);
        chk("rst_ptr",   {26'd0, prog_ptr}, 32'd0);
        chk("rst_flags", {28'd0, bad_start, prog_wr_err, done, cmd_fifo_wr_en}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        prog_addr  = a;
        prog_data  = d;
        prog_wr_en = 1'b1;
        tick();
        prog_wr_en = 1'b0;
    endtask

    // Expected word stream for a normally completing run.
    task automatic build_exp(input int len, input int lc);
        exp_q.delete();
        for (int l = 0; l < lc; l++) begin
            for (int i = 0; i < len; i++) exp_q.push_back(prog_mem[i]);
`ifdef SHIM_TRIGGER_SEQ_LOOP_SYNC_EN
            exp_q.push_back(W_SYNC);
`endif
        end
    endtask

    // Pulse start, then drive full/abort/stray writes per cycle and record
    // every FIFO write until done plus one cycle (or max_cyc expires).
    task automatic run(input logic [6:0] len, input logic [15:0] lc, input int max_cyc,
                       input int full_start, input int full_len,
                       input int abort_after, input int wr_cyc);
        int nw;
        bit aborted;
        bit done_seen;
        nw = 0; aborted = 0; done_seen = 0;
        got_q.delete();
        done_cnt = 0; full_viol = 0; busy_after_done = -1; busy_seen = 0; timed_out = 1;
        prog_len   = len;
        loop_count = lc;
        for (int c = 0; c < max_cyc; c++) begin
            start         = (c == 0);
            cmd_fifo_full = (c >= full_start) && (c < full_start + full_len);
            abort         = 1'b0;
            if (abort_after >= 0 && !aborted && nw == abort_after) begin
                abort   = 1'b1;
                aborted = 1;
            end
            prog_wr_en = (c == wr_cyc);
            prog_addr  = '0;
            prog_data  = 32'hDEAD_BEEF;
            @(negedge clk);
            if (done_seen) begin
                busy_after_done = int'(busy);
                timed_out       = 0;
            end else begin
                if (busy) busy_seen = 1;
                if (cmd_fifo_wr_en) begin
                    got_q.push_back(cmd_fifo_wr_data);
                    nw++;
                    if (cmd_fifo_full) full_viol++;
                end
                if (done) begin
                    done_cnt++;
                    done_seen = 1;
                end
            end
            @(posedge clk);
            #1;
            if (timed_out == 0) break;
        end
        start = 1'b0; abort = 1'b0; cmd_fifo_full = 1'b0; prog_wr_en = 1'b0;
    endtask

    task automatic chk_words(input string tag);
        chk({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    vec_t vecs [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; prog_addr = '0; prog_data = '0; prog_len = '0; loop_count = '0;
        start = 1'b0; abort = 1'b0; prog_wr_en = 1'b0; cmd_fifo_full = 1'b0;

        vecs[0] = '{len: 7'd3,  lc: 16'd2, full_start: 1000, full_len: 0,  exp_loops: 16'd2};
        vecs[1] = '{len: 7'd3,  lc: 16'd2, full_start: 3,    full_len: 10, exp_loops: 16'd2};
        vecs[2] = '{len: 7'd1,  lc: 16'd1, full_start: 1000, full_len: 0,  exp_loops: 16'd1};
        vecs[3] = '{len: 7'd64, lc: 16'd1, full_start: 20,   full_len: 3,  exp_loops: 16'd1};
        vecs[4] = '{len: 7'd4,  lc: 16'd3, full_start: 0,    full_len: 5,  exp_loops: 16'd3};
        vecs[5] = '{len: 7'd2,  lc: 16'd2, full_start: 6,    full_len: 1,  exp_loops: 16'd2};

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0:       prog_mem[i] = 32'hA000_0010;
                1:       prog_mem[i] = 32'h8000_0005;
                2:       prog_mem[i] = 32'hA000_0001;
                default: prog_mem[i] = 32'h4000_0000 | i;
            endcase
            load_word(AW'(i), prog_mem[i]);
        end

        for (int v = 0; v < 6; v++) begin
            do_reset();
            run(vecs[v].len, vecs[v].lc, 1000, vecs[v].full_start, vecs[v].full_len, -1, -1);
            build_exp(int'(vecs[v].len), int'(vecs[v].lc));
            chk($sformatf("v%0d_timeout", v), timed_out, 0);
            chk_words($sformatf("v%0d", v));
            chk($sformatf("v%0d_loops", v), {16'd0, loops_done}, {16'd0, vecs[v].exp_loops});
            chk($sformatf("v%0d_done", v), done_cnt, 1);
            chk($sformatf("v%0d_fullviol", v), full_viol, 0);
            chk($sformatf("v%0d_busy_after", v), busy_after_done, 0);
            chk($sformatf("v%0d_bad", v), {31'd0, bad_start}, 32'd0);
        end

        // Illegal lengths, then a legal run: bad_start stays set.
        do_reset();
        run(7'd0, 16'd1, 8, 1000, 0, -1, -1);
        chk("bad0_flag", {31'd0, bad_start}, 32'd1);
        chk("bad0_nwr", got_q.size(), 0);
        chk("bad0_busy", busy_seen, 0);
        run(7'd65, 16'd1, 8, 1000, 0, -1, -1);
        chk("bad65_flag", {31'd0, bad_start}, 32'd1);
        chk("bad65_nwr", got_q.size(), 0);
        chk("bad65_busy", busy_seen, 0);
        run(7'd3, 16'd1, 200, 1000, 0, -1, -1);
        build_exp(3, 1);
        chk_words("after_bad");
        chk("bad_sticky", {31'd0, bad_start}, 32'd1);

        // Endless loop of one word, aborted once 5 words have gone out.
        do_reset();
        run(7'd1, 16'd0, 300, 1000, 0, 5, -1);
        exp_q.delete();
`ifdef SHIM_TRIGGER_SEQ_LOOP_SYNC_EN
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(prog_mem[0]);
            exp_q.push_back(W_SYNC);
        end
        exp_q.push_back(W_CANCEL);
        chk("abort_loops", {16'd0, loops_done}, 32'd3);
`else
        for (int i = 0; i < 5; i++) exp_q.push_back(prog_mem[0]);
        exp_q.push_back(W_CANCEL);
        chk("abort_loops", {16'd0, loops_done}, 32'd5);
`endif
        chk_words("abort");
        chk("abort_done", done_cnt, 1);
        chk("abort_busy_after", busy_after_done, 0);

        // Program write while busy is dropped and flagged.
        do_reset();
        run(7'd3, 16'd1, 200, 1000, 0, -1, 3);
        chk("wrerr_flag", {31'd0, prog_wr_err}, 32'd1);
        run(7'd3, 16'd1, 200, 1000, 0, -1, -1);
        build_exp(3, 1);
        chk_words("wrerr_replay");
        chk("wrerr_sticky", {31'd0, prog_wr_err}, 32'd1);

        // Reset mid-sequence: straight back to idle, no cancel word.
        do_reset();
        prog_len   = 7'd3;
        loop_count = 16'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_wr", {31'd0, cmd_fifo_wr_en}, 32'd0);
        chk("midrst_ptr", {26'd0, prog_ptr}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_wr_after", {31'd0, cmd_fifo_wr_en}, 32'd0);
        chk("midrst_busy_after", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
